// File: rtl/mul_sched_pkg.sv
// Shared types and datapath control codes for the shift-add multiply scheduler.
package mul_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVAL,
      SHIFT,
      DONE
   } state_t;

   localparam logic [1:0] SH_HOLD  = 2'd0;
   localparam logic [1:0] SH_RIGHT = 2'd1;
   localparam logic [1:0] SH_LOAD  = 2'd2;

   localparam logic [1:0] ACC_HOLD = 2'd0;
   localparam logic [1:0] ACC_CLR  = 2'd1;
   localparam logic [1:0] ACC_ADD  = 2'd2;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mul_sched_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to whoever was not served last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = 1'b0;
      unique case (req)
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last;
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/mul_sched.sv
// Scheduler/controller for a shared shift-add multiplier with two requesters.
// Optional: MUL_SCHED_EARLY_EXIT_EN ends an operation once the multiplier is exhausted.
module mul_sched
   import mul_sched_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [1:0]               req,
   input  logic                     q,
   input  logic                     mz,
   output logic [1:0]               gnt,
   output logic                     sel,
   output logic [1:0]               c_sh,
   output logic [1:0]               c_acc,
   output logic [1:0]               done,
   output logic                     busy,
   output logic [$clog2(N+1)-1:0]   k
);

   localparam int KW = $clog2(N+1);

   state_t state, state_nx;
   logic   last;
   logic   win;
   logic   win_vld;

   rr_arb2 u_arb (
      .req    (req),
      .last   (last),
      .winner (win),
      .valid  (win_vld)
   );

   // reset is active low
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sel   <= 1'b0;
         last  <= 1'b1;
         k     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && win_vld) begin
            sel  <= win;
            last <= win;
            k    <= '0;
         end else if (state == SHIFT) begin
            k <= k + KW'(1);
         end
      end
   end

`ifndef MUL_SCHED_EARLY_EXIT_EN
   logic mz_unused;
   assign mz_unused = mz;
`endif

   always_comb begin
      state_nx = state;
      gnt      = 2'b00;
      c_sh     = SH_HOLD;
      c_acc    = ACC_HOLD;
      done     = 2'b00;
      unique case (state)
         IDLE: begin
            if (win_vld) state_nx = LOAD;
         end
         LOAD: begin
            gnt      = onehot2(sel);
            c_sh     = SH_LOAD;
            c_acc    = ACC_CLR;
            state_nx = EVAL;
         end
         EVAL: begin
            gnt   = onehot2(sel);
            c_acc = q ? ACC_ADD : ACC_HOLD;
`ifdef MUL_SCHED_EARLY_EXIT_EN
            state_nx = mz ? DONE : SHIFT;
`else
            state_nx = SHIFT;
`endif
         end
         SHIFT: begin
            gnt      = onehot2(sel);
            c_sh     = SH_RIGHT;
            // k is about to increment; finish when it reaches N
            state_nx = (k == KW'(N - 1)) ? DONE : EVAL;
         end
         DONE: begin
            gnt      = onehot2(sel);
            done     = onehot2(sel);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (!reset) c_acc = ACC_CLR;
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: a datapath model closes the q/mz loop.
// Expected product, grant, latency and add count are queued when requests are made.
module tb_mul_sched;
   import mul_sched_pkg::*;

   localparam int N  = 8;
   localparam int KW = $clog2(N+1);

   typedef struct {
      logic       idx;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   logic          clock;
   logic          reset;
   logic [1:0]    req;
   logic          q;
   logic          mz;
   logic [1:0]    gnt;
   logic          sel;
   logic [1:0]    c_sh;
   logic [1:0]    c_acc;
   logic [1:0]    done;
   logic          busy;
   logic [KW-1:0] k;

   logic [7:0]    a_op [2];
   logic [7:0]    b_op [2];
   logic [7:0]    mr;
   logic [15:0]   md;
   logic [15:0]   acc;

   exp_t sb [$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   t0 = 0;
   int   adds = 0;
   bit   after_done = 0;

   mul_sched #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .q     (q),
      .mz    (mz),
      .gnt   (gnt),
      .sel   (sel),
      .c_sh  (c_sh),
      .c_acc (c_acc),
      .done  (done),
      .busy  (busy),
      .k     (k)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sig_bits(input logic [7:0] b);
      int l = 0;
      for (int i = 0; i < N; i++) if (b[i]) l = i + 1;
      return l;
   endfunction

   function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_SCHED_EARLY_EXIT_EN
      int l = sig_bits(b);
      return (l < N) ? 2 * l + 2 : 2 * N + 1;
`else
      return 2 * N + 1;
`endif
   endfunction

   function automatic int exp_k(input logic [7:0] b);
`ifdef MUL_SCHED_EARLY_EXIT_EN
      int l = sig_bits(b);
      return (l < N) ? l : N;
`else
      return N;
`endif
   endfunction

   // shared datapath: multiplier shift register, shifted multiplicand, accumulator
   assign q  = mr[0];
   assign mz = (mr == 8'h00);

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mr  <= '0;
         md  <= '0;
         acc <= '0;
      end else begin
         if (c_sh == SH_LOAD) begin
            mr <= b_op[sel];
            md <= {8'h00, a_op[sel]};
         end else if (c_sh == SH_RIGHT) begin
            mr <= mr >> 1;
            md <= md << 1;
         end
         if (c_acc == ACC_CLR) acc <= '0;
         else if (c_acc == ACC_ADD) acc <= acc + md;
      end
   end

   always @(negedge clock) begin
      exp_t e;
      cyc++;
      if (reset) begin
         if (after_done) begin
            chk("gap_gnt", {30'd0, gnt}, 32'd0);
            chk("gap_busy", {31'd0, busy}, 32'd0);
            after_done = 0;
         end
         if (busy && c_sh == SH_LOAD) begin
            t0   = cyc;
            adds = 0;
            if (sb.size() == 0) begin
               chk("unexpected_load", {30'd0, gnt}, 32'd0);
            end else begin
               chk("load_gnt", {30'd0, gnt}, {30'd0, onehot2(sb[0].idx)});
               chk("load_k", {28'd0, k}, 32'd0);
            end
         end
         if (c_acc == ACC_ADD) adds++;
         if (done != 2'b00) begin
            if (sb.size() == 0) begin
               chk("spurious_done", {30'd0, done}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done", {30'd0, done}, {30'd0, onehot2(e.idx)});
               chk("done_gnt", {30'd0, gnt}, {30'd0, onehot2(e.idx)});
               chk("latency", cyc - t0, exp_lat(e.b));
               chk("adds", adds, $countones(e.b));
               chk("k_final", {28'd0, k}, exp_k(e.b));
               chk("product", {16'd0, acc}, {16'd0, e.a} * {24'd0, e.b});
            end
            after_done = 1;
         end
      end else begin
         after_done = 0;
      end
   end

   task automatic serve(input int n);
      int got = 0;
      int t = 0;
      while (got < n && t < 400) begin
         @(negedge clock);
         t++;
         if (done != 2'b00) got++;
      end
      if (got < n) chk("timeout_done", got, n);
      req = 2'b00;
   endtask

   task automatic wait_load();
      int t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!(busy && c_sh == SH_LOAD) && t < 50);
      if (t >= 50) chk("timeout_load", {30'd0, c_sh}, {30'd0, SH_LOAD});
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
      chk({tag, "_sel"}, {31'd0, sel}, 32'd0);
      chk({tag, "_csh"}, {30'd0, c_sh}, {30'd0, SH_HOLD});
      chk({tag, "_cacc"}, {30'd0, c_acc}, {30'd0, ACC_CLR});
      chk({tag, "_done"}, {30'd0, done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_k"}, {28'd0, k}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      #1 check_reset_vals("rst");
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic push_op(input logic idx, input logic [7:0] a,
                          input logic [7:0] b);
      exp_t e;
      e.idx = idx;
      e.a = a;
      e.b = b;
      a_op[idx] = a;
      b_op[idx] = b;
      sb.push_back(e);
   endtask

   initial begin
      logic [7:0] btab [4];
      btab[0] = 8'h00;
      btab[1] = 8'hFF;
      btab[2] = 8'h80;
      btab[3] = 8'h3C;
      reset = 1'b0;
      req = 2'b00;
      a_op[0] = '0; a_op[1] = '0;
      b_op[0] = '0; b_op[1] = '0;
      repeat (2) @(negedge clock);
      #1 check_reset_vals("por");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_cacc", {30'd0, c_acc}, {30'd0, ACC_HOLD});

      // multiplier 0x05 from requester 0
      push_op(1'b0, 8'h13, 8'h05);
      req = 2'b01;
      serve(1);

      // both requesting from reset: 0, 1, 0
      pulse_reset();
      push_op(1'b0, 8'hA7, 8'h5A);
      push_op(1'b1, 8'h3E, 8'hC3);
      push_op(1'b0, 8'hA7, 8'h5A);
      req = 2'b11;
      serve(3);

      // requester drops its request at cycle 5
      push_op(1'b0, 8'h21, 8'h96);
      req = 2'b01;
      wait_load();
      repeat (4) @(negedge clock);
      req = 2'b00;
      serve(1);

      // reset inside SHIFT at cycle 9
      push_op(1'b0, 8'h55, 8'hAA);
      req = 2'b01;
      wait_load();
      repeat (8) @(negedge clock);
      chk("mid_shift", {30'd0, c_sh}, {30'd0, SH_RIGHT});
      reset = 1'b0;
      req = 2'b00;
      #1 check_reset_vals("mid");
      sb.delete();
      repeat (2) begin
         @(negedge clock);
         chk("mid_nodone", {30'd0, done}, 32'd0);
      end
      reset = 1'b1;
      @(negedge clock);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_cacc", {30'd0, c_acc}, {30'd0, ACC_HOLD});

      // quiet idle
      repeat (20) begin
         @(negedge clock);
         chk("idle_busy", {31'd0, busy}, 32'd0);
         chk("idle_gnt", {30'd0, gnt}, 32'd0);
         chk("idle_csh", {30'd0, c_sh}, {30'd0, SH_HOLD});
         chk("idle_cacc", {30'd0, c_acc}, {30'd0, ACC_HOLD});
         chk("idle_k", {28'd0, k}, 32'd0);
      end

      // multiplier 0x01 (early exit candidate)
      push_op(1'b1, 8'hE9, 8'h01);
      req = 2'b10;
      serve(1);

      for (int i = 0; i < 4; i++) begin
         logic idx;
         idx = i[0];
         push_op(idx, 8'($urandom_range(0, 255)), btab[i]);
         req = onehot2(idx);
         serve(1);
      end

      repeat (3) @(negedge clock);
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter N, default 8, operand width in bits, and iteration count of the shift-add multiply.
REQ-002 clock  in  1  single clock for all state; rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req  in  2  per-requester multiply request; held high by the requester until its done pulse.
REQ-005 q  in  1  current multiplier LSB from the shared datapath.
REQ-006 mz  in  1  datapath flag: remaining multiplier bits all zero.
REQ-007 gnt  out  2  one-hot grant; held for the whole operation.
REQ-008 sel  out  1  operand mux select (index of the granted requester).
REQ-009 c_sh  out  2  shift-register code: 0 hold, 1 shift right, 2 load.
REQ-010 c_acc  out  2  accumulator code: 0 hold, 1 clear, 2 add.
REQ-011 done  out  2  one-cycle completion pulse to the granted requester.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 k  out  $clog2(N+1)  completed-iteration count.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LOAD, EVAL, SHIFT, DONE.
REQ-015 IDLE: gnt=0, c_sh=0, c_acc=0, done=0; on any req bit high, the FSM SHALL register the arbiter winner and go to LOAD next cycle.
REQ-016 Arbitration SHALL be round-robin on the last-served index: single request wins; if both request, the one not last served wins; after reset req[0] wins the first tie.
REQ-017 LOAD (1 cycle): gnt and sel valid, c_sh=2, c_acc=1, k cleared to 0; next state EVAL.
REQ-018 EVAL (1 cycle): c_acc=2 if q=1, else 0; c_sh=0; next state SHIFT.
REQ-019 SHIFT (1 cycle): c_sh=1, c_acc=0, k increments; next state DONE if the incremented k equals N, else EVAL.
REQ-020 DONE (1 cycle): done[sel]=1, gnt still asserted, c_sh=0, c_acc=0; next state IDLE.
REQ-021 Latency SHALL be fixed: request seen in IDLE at cycle 0 gives LOAD at cycle 1 and DONE at cycle 2N+2.
REQ-022 At least one IDLE cycle SHALL separate consecutive operations; gnt drops in that IDLE cycle.
REQ-023 Deassertion of the granted req mid-operation SHALL NOT abort; the operation completes and done still pulses.
REQ-024 A request from the other requester during an operation SHALL be held off and served in the next IDLE under REQ-016.
REQ-025 k SHALL never exceed N; sel SHALL be stable from LOAD through DONE.

Reset
REQ-026 reset low SHALL force, asynchronously: state IDLE, gnt=0, sel=0, c_sh=0, c_acc=1, done=0, busy=0, k=0, last-served pointer = 1.
REQ-027 Reset asserted mid-operation SHALL abort with no done pulse; the first cycle after release is IDLE.

Configuration
REQ-028 Macro MUL_SCHED_EARLY_EXIT_EN: when defined, EVAL with mz=1 SHALL go directly to DONE (latency data-dependent, minimum 3 cycles LOAD->DONE inclusive); when undefined, mz SHALL be ignored and latency SHALL be exactly REQ-021.

Structure
REQ-029 Package mul_sched_pkg SHALL hold the state enum and the c_sh/c_acc code constants (SH_HOLD, SH_RIGHT, SH_LOAD, ACC_HOLD, ACC_CLR, ACC_ADD), shared with the datapath.
REQ-030 The round-robin arbiter SHALL be a separate sub-module rr_arb2 (req[1:0], last, winner, valid), purely combinational.

Verification
REQ-031 N=8, req=01, q pattern from multiplier 0x05 -> gnt=01 at cycle 1, c_acc=2 in EVALs of iterations 0 and 2 only, done=01 at cycle 18.
REQ-032 req=11 held continuously after reset -> grants alternate 01,10,01; each done followed by one IDLE cycle with gnt=00.
REQ-033 req[0] dropped at cycle 5 of an operation -> sequence unchanged, done=01 at cycle 18.
REQ-034 reset low at cycle 9 (inside SHIFT) -> outputs at reset values immediately, no done pulse, IDLE after release.
REQ-035 With MUL_SCHED_EARLY_EXIT_EN, multiplier 0x01 (mz=1 after first shift) -> DONE at cycle 5; without it, DONE at cycle 18.
REQ-036 Idle with req=00 for 20 cycles -> busy=0, gnt=00, c_sh=0, c_acc=0, k constant.
